// File: rtl/alu_seq_pkg.sv
// Shared opcodes, error bit indices and FSM state type for the ALU sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_CLEAR      = 4'b0000;
    localparam logic [3:0] OP_LOAD       = 4'b0001;
    localparam logic [3:0] OP_ADD        = 4'b0010;
    localparam logic [3:0] OP_SUB        = 4'b0011;
    localparam logic [3:0] OP_MUL        = 4'b0100;
    localparam logic [3:0] OP_DIV        = 4'b0101;
    localparam logic [3:0] OP_MOD        = 4'b0110;
    localparam logic [3:0] OP_LAST_LEGAL = 4'b0110;

    localparam int ERR_OVF = 0;
    localparam int ERR_DZ  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } seq_state_t;

    // CLEAR, LOAD and every illegal opcode complete without touching the ALU.
    function automatic logic isLocalOp(input logic [3:0] op);
        return (op == OP_CLEAR) || (op == OP_LOAD) || (op > OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/BreadBoard.sv
// Combinational 16x16 ALU: ADD/SUB/MUL/DIV/MOD with overflow (borrow) and divide-by-zero flags.
module BreadBoard
    import alu_seq_pkg::*;
(
    input  logic [15:0] IN1,
    input  logic [15:0] IN2,
    input  logic [3:0]  OP,
    output logic [31:0] OUT,
    output logic [1:0]  ERR
);

    // Pure combinational datapath; a grounded or local opcode yields zero.
    always_comb begin
        OUT = '0;
        ERR = '0;
        case (OP)
            OP_ADD: OUT = {16'b0, IN1} + {16'b0, IN2};
            OP_SUB: begin
                OUT          = {16'b0, IN1} - {16'b0, IN2};
                ERR[ERR_OVF] = (IN1 < IN2);
            end
            OP_MUL: OUT = {16'b0, IN1} * {16'b0, IN2};
            OP_DIV: begin
                if (IN2 == 16'd0) ERR[ERR_DZ] = 1'b1;
                else              OUT = {16'b0, IN1 / IN2};
            end
            OP_MOD: begin
                if (IN2 == 16'd0) ERR[ERR_DZ] = 1'b1;
                else              OUT = {16'b0, IN1 % IN2};
            end
            default: begin
                OUT = '0;
                ERR = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_settle_timer.sv
// Loadable down-counter that flags the last settle cycle of an ALU operation.
module alu_seq_settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    // Load the full settle interval on issue, then count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(SETTLE_CYCLES);
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Registered command front-end: issues one command at a time to the combinational
// ALU, waits for it to settle, captures the result into the accumulator and returns it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_src,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        rsp_ill,
    output logic        rsp_trunc,
    output logic [1:0]  err_sticky,
    output logic [31:0] acc
);

    seq_state_t  r_state;
    seq_state_t  w_nextState;

    logic [31:0] r_acc;
    logic [1:0]  r_errSticky;
    logic [15:0] r_aluIn1;
    logic [15:0] r_aluIn2;
    logic [3:0]  r_aluOp;
    logic [31:0] r_rspData;
    logic [1:0]  r_rspErr;
    logic        r_rspIll;
    logic        r_rspTrunc;

    logic        w_accept;
    logic        w_isIll;
    logic        w_isLocal;
    logic        w_rspTake;
    logic        w_timerDone;
    logic [15:0] w_in1;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_isIll   = (cmd_op > OP_LAST_LEGAL);
    assign w_isLocal = isLocalOp(cmd_op);
    assign w_rspTake = rsp_valid && rsp_ready;
    assign w_in1     = cmd_src ? r_acc[15:0] : cmd_a;

    alu_seq_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settleTimer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && !w_isLocal),
        .o_done (w_timerDone)
    );

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state logic: local ops answer immediately, ALU ops wait out the settle interval.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_nextState = w_isLocal ? S_RESP : S_WAIT;
            S_WAIT:    if (w_timerDone) w_nextState = S_CAPTURE;
            S_CAPTURE: w_nextState = S_RESP;
            S_RESP:    if (rsp_ready) w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; nothing is accepted while reset is held.
    always_comb begin
        cmd_ready = (r_state == S_IDLE) && !rst;
        rsp_valid = (r_state == S_RESP);
    end

    // Datapath registers: operand latch on accept, result capture, op grounding on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_errSticky <= '0;
            r_aluIn1    <= '0;
            r_aluIn2    <= '0;
            r_aluOp     <= '0;
            r_rspData   <= '0;
            r_rspErr    <= '0;
            r_rspIll    <= 1'b0;
            r_rspTrunc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rspIll   <= w_isIll;
                r_rspTrunc <= cmd_src && (r_acc[31:16] != 16'd0);
                r_rspErr   <= '0;
                if (w_isIll) begin
                    r_rspData <= r_acc;
                end else begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            r_acc       <= '0;
                            r_errSticky <= '0;
                            r_rspData   <= '0;
                        end
                        OP_LOAD: begin
                            r_acc     <= {16'b0, cmd_a};
                            r_rspData <= {16'b0, cmd_a};
                        end
                        default: begin
                            r_aluIn1 <= w_in1;
                            r_aluIn2 <= cmd_b;
                            r_aluOp  <= cmd_op;
                        end
                    endcase
                end
            end
            if (r_state == S_CAPTURE) begin
                r_acc       <= alu_out;
                r_rspData   <= alu_out;
                r_rspErr    <= alu_err;
                r_errSticky <= r_errSticky | alu_err;
            end
            if (w_rspTake) begin
                r_aluOp <= OP_CLEAR;
            end
        end
    end

    assign alu_in1    = r_aluIn1;
    assign alu_in2    = r_aluIn2;
    assign alu_op     = r_aluOp;
    assign rsp_data   = r_rspData;
    assign rsp_err    = r_rspErr;
    assign rsp_ill    = r_rspIll;
    assign rsp_trunc  = r_rspTrunc;
    assign err_sticky = r_errSticky;
    assign acc        = r_acc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving the BreadBoard ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int SETTLE = 4;
    localparam int ALU_LAT = SETTLE + 1;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expIn1;
        logic [31:0] expData;
        logic [1:0]  expErr;
        logic        expIll;
        logic        expTrunc;
        logic [1:0]  expSticky;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic        cmd_src;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic [1:0]  alu_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        rsp_ill;
    logic        rsp_trunc;
    logic [1:0]  err_sticky;
    logic [31:0] acc;

    int checkCount = 0;
    int passCount  = 0;

    vec_t vecs[14];

    // Free-running clock.
    always #5 clk = ~clk;

    alu_sequencer #(
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_err    (alu_err),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_ill    (rsp_ill),
        .rsp_trunc  (rsp_trunc),
        .err_sticky (err_sticky),
        .acc        (acc)
    );

    BreadBoard u_alu (
        .IN1 (alu_in1),
        .IN2 (alu_in2),
        .OP  (alu_op),
        .OUT (alu_out),
        .ERR (alu_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Waits for cmd_ready, presents one command for one edge, then counts edges until rsp_valid.
    task automatic applyStimulus(input vec_t v, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("cmd_ready before accept", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_src   = v.src;
        cmd_a     = v.a;
        cmd_b     = v.b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (v.expLat != 1) begin
            check("alu_op latched", {28'b0, alu_op}, {28'b0, v.op});
            check("alu_in1 latched", {16'b0, alu_in1}, {16'b0, v.expIn1});
            check("alu_in2 latched", {16'b0, alu_in2}, {16'b0, v.b});
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 50);
    endtask

    // Compares the held response against the vector, then consumes it.
    task automatic checkOutput(input vec_t v, input int lat);
        check("latency", lat, v.expLat);
        check("rsp_data", rsp_data, v.expData);
        check("rsp_err", {30'b0, rsp_err}, {30'b0, v.expErr});
        check("rsp_ill", {31'b0, rsp_ill}, {31'b0, v.expIll});
        check("rsp_trunc", {31'b0, rsp_trunc}, {31'b0, v.expTrunc});
        check("err_sticky", {30'b0, err_sticky}, {30'b0, v.expSticky});
        check("acc", acc, v.expData);
        check("cmd_ready in RESP", {31'b0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid after take", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready after take", {31'b0, cmd_ready}, 32'd1);
        check("alu_op grounded", {28'b0, alu_op}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   lat;
        logic stable;
        logic seen;

        //            op      src   a       b       in1      data             err    ill   tr    st     lat
        vecs[0]  = '{OP_ADD,  1'b0, 16'd11, 16'd51, 16'd11,  32'd62,          2'b00, 1'b0, 1'b0, 2'b00, ALU_LAT};
        vecs[1]  = '{4'b1000, 1'b0, 16'd7,  16'd9,  16'd0,   32'd62,          2'b00, 1'b1, 1'b0, 2'b00, 1};
        vecs[2]  = '{4'b1111, 1'b1, 16'd0,  16'd0,  16'd0,   32'd62,          2'b00, 1'b1, 1'b0, 2'b00, 1};
        vecs[3]  = '{OP_LOAD, 1'b0, 16'd11, 16'd0,  16'd0,   32'd11,          2'b00, 1'b0, 1'b0, 2'b00, 1};
        vecs[4]  = '{OP_SUB,  1'b1, 16'd99, 16'd51, 16'd11,  32'hFFFF_FFD8,   2'b01, 1'b0, 1'b0, 2'b01, ALU_LAT};
        vecs[5]  = '{OP_MUL,  1'b1, 16'd0,  16'd2,  16'hFFD8, 32'h0001_FFB0,  2'b00, 1'b0, 1'b1, 2'b01, ALU_LAT};
        vecs[6]  = '{OP_ADD,  1'b1, 16'd0,  16'd1,  16'hFFB0, 32'h0000_FFB1,  2'b00, 1'b0, 1'b1, 2'b01, ALU_LAT};
        vecs[7]  = '{OP_CLEAR,1'b0, 16'd0,  16'd0,  16'd0,   32'd0,           2'b00, 1'b0, 1'b0, 2'b00, 1};
        vecs[8]  = '{OP_MUL,  1'b0, 16'd62091, 16'd47411, 16'd62091, 32'd2943796401, 2'b00, 1'b0, 1'b0, 2'b00, ALU_LAT};
        vecs[9]  = '{OP_DIV,  1'b0, 16'd11, 16'd0,  16'd11,  32'd0,           2'b10, 1'b0, 1'b0, 2'b10, ALU_LAT};
        vecs[10] = '{OP_DIV,  1'b0, 16'd100, 16'd7, 16'd100, 32'd14,          2'b00, 1'b0, 1'b0, 2'b10, ALU_LAT};
        vecs[11] = '{OP_MOD,  1'b0, 16'd100, 16'd7, 16'd100, 32'd2,           2'b00, 1'b0, 1'b0, 2'b10, ALU_LAT};
        vecs[12] = '{OP_MOD,  1'b0, 16'd5,  16'd0,  16'd5,   32'd0,           2'b10, 1'b0, 1'b0, 2'b10, ALU_LAT};
        vecs[13] = '{OP_CLEAR,1'b0, 16'd0,  16'd0,  16'd0,   32'd0,           2'b00, 1'b0, 1'b0, 2'b00, 1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_src   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset acc", acc, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput(vecs[i], lat);
        end

        // Response held back for five cycles while a command is offered.
        v = '{OP_ADD, 1'b0, 16'd1, 16'd2, 16'd1, 32'd3, 2'b00, 1'b0, 1'b0, 2'b00, ALU_LAT};
        applyStimulus(v, lat);
        check("hold latency", lat, ALU_LAT);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_LOAD;
                cmd_src   = 1'b0;
                cmd_a     = 16'd999;
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            if (!(rsp_valid && !cmd_ready && rsp_data == 32'd3 && rsp_err == 2'b00 &&
                  !rsp_ill && !rsp_trunc)) stable = 1'b0;
        end
        check("hold stable", {31'b0, stable}, 32'd1);
        checkOutput(v, ALU_LAT);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("ignored cmd no rsp", {31'b0, seen}, 32'd0);
        check("ignored cmd acc", acc, 32'd3);

        // Reset while the ALU operation is settling.
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_src   = 1'b0;
        cmd_a     = 16'd5;
        cmd_b     = 16'd6;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("abort alu_in1", {16'b0, alu_in1}, 32'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort acc", acc, 32'd0);
        check("abort alu_in1 reset", {16'b0, alu_in1}, 32'd0);
        check("abort alu_in2 reset", {16'b0, alu_in2}, 32'd0);
        check("abort alu_op reset", {28'b0, alu_op}, 32'd0);
        check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort rsp_data", rsp_data, 32'd0);
        check("abort cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (SETTLE + 4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort no response", {31'b0, seen}, 32'd0);
        applyStimulus(vecs[0], lat);
        checkOutput(vecs[0], lat);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
